ball_motion_ctrl: RTL and testbench
===================================

Name: ball_motion_ctrl

Overview:
- Per-frame position controller for the Pong ball rectangle.
- Once per frame, at the start of vertical blanking, it advances the ball position by a fixed step and bounces off the top and bottom walls.
- It detects misses at the left and right screen edges and re-serves the ball on a miss or a serve request.
- Its registered xpos/ypos outputs drive the position inputs of a runtime-positioned rectangle generator; positions never change during active video.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame; y == V_ACTIVE is the first blanking line.
- BALL_SIZE, 8, ball width and height in pixels.
- WALL_H, 10, height of the top and bottom walls in lines.
- X_START, 316, serve x position.
- Y_START, 236, serve y position.
- STEP, 2, pixels moved per frame on each axis.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  synchronous active-low reset.
- y  in  10  current scan line from the VGA timing generator.
- run  in  1  1 = ball moves; 0 = frozen (FSM still cycles each frame).
- serve  in  1  request re-serve; level sampled every cycle.
- xpos  out  11  ball left edge.
- ypos  out  10  ball top edge.
- dir_x  out  1  1 = moving right, 0 = moving left.
- dir_y  out  1  1 = moving down, 0 = moving up.
- frame_done  out  1  one-cycle pulse when a new position is committed.
- hit_top  out  1  one-cycle pulse, coincident with frame_done.
- hit_bottom  out  1  one-cycle pulse, coincident with frame_done.
- miss_left  out  1  one-cycle pulse, coincident with frame_done.
- miss_right  out  1  one-cycle pulse, coincident with frame_done.

Behaviour:
- Reset (rst_n = 0 at an edge): xpos = X_START, ypos = Y_START, dir_x = 1, dir_y = 1. All pulses = 0. State = IDLE. y_prev = 0. serve_pend = 0. Reset mid-operation aborts the update and emits no pulses.
- Frame tick: tick = (y == V_ACTIVE) && (y_prev != V_ACTIVE); y_prev is registered every cycle. Holding y at V_ACTIVE produces exactly one tick.
- FSM states: IDLE, CALC, RESOLVE, COMMIT.
  - IDLE to CALC at an edge where tick = 1.
  - CALC to RESOLVE, RESOLVE to COMMIT, COMMIT to IDLE, one cycle each, unconditionally.
  - A tick arriving outside IDLE is ignored; it cannot occur in practice.
- CALC: compute candidates nx and ny at 12-bit signed width.
  - s = STEP if run = 1, else 0.
  - nx = xpos + s if dir_x = 1, else xpos - s.
  - ny = ypos + s if dir_y = 1, else ypos - s.
- RESOLVE, with YMIN = WALL_H, YMAX = V_ACTIVE - WALL_H - BALL_SIZE (462), XMAX = H_ACTIVE - BALL_SIZE (632):
  - dir_y = 1 and ny > YMAX: ny = YMAX, flip dir_y, set hit_bottom.
  - dir_y = 0 and ny < YMIN: ny = YMIN, flip dir_y, set hit_top.
  - Equality with a bound is legal and does not bounce.
  - dir_x = 0 and nx < 0: set miss_left, nx = X_START, ny = Y_START, dir_x = 1.
  - dir_x = 1 and nx > XMAX: set miss_right, nx = X_START, ny = Y_START, dir_x = 0.
  - Simultaneous y-hit and x-miss: both pulses fire. The miss position wins; the dir_y flip is kept.
- Serve: serve = 1 in any cycle sets serve_pend.
  - At COMMIT, if serve_pend is set: nx = X_START and ny = Y_START; directions are unchanged and no hit/miss pulses fire. serve_pend is cleared.
  - A serve asserted in the same cycle as COMMIT is applied at the next frame.
- COMMIT: xpos, ypos, dir_x, dir_y and the event pulses are registered at the edge leaving COMMIT.
  - frame_done = 1 for that following cycle only.
  - Latency: tick edge E0, outputs valid after E3 (3 cycles).
- run = 0: s = 0, so no movement and no bounce or miss. frame_done still pulses each frame.

Decomposition:
- Shared package pong_pkg:
  - state enum: IDLE, CALC, RESOLVE, COMMIT.
  - direction constants: DIR_LEFT/UP = 0, DIR_RIGHT/DOWN = 1.
  - screen geometry constants H_ACTIVE and V_ACTIVE, for reuse by the paddle controllers.
- One natural sub-module: vblank_tick, containing the y_prev register and tick compare; it will be reused by the paddle controllers.

Test Plan:
- Reset: hold rst_n = 0, then release -> xpos = 316, ypos = 236, dir_x = 1, dir_y = 1; no pulses until the first tick.
- Single frame, run = 1: y steps 479 to 480 -> 3 edges later xpos = 318, ypos = 238; frame_done high exactly 1 cycle. Holding y = 480 for 100 cycles gives no further update.
- Bottom bounce: run 113 frames -> ypos = 462, dir_y = 1, no hit. Frame 114 -> ypos = 462, dir_y = 0, hit_bottom = 1 with frame_done.
- Right miss: frame 158 -> xpos = 632, no miss. Frame 159 -> miss_right = 1, xpos = 316, ypos = 236, dir_x = 0.
- Freeze and serve: run = 0 over 5 frames -> positions unchanged and 5 frame_done pulses. Then run = 1 with a one-cycle serve during RESOLVE -> that COMMIT yields 316/236, no event pulses, directions unchanged.
- Reset mid-update: rst_n = 0 at the CALC edge -> next cycle shows reset values, frame_done = 0, state IDLE; the next tick updates normally from 316/236.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong definitions: screen geometry, direction encodings and controller FSM states.
// Used by the ball controller and the paddle controllers.
package pong_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t CALC    = 2'd1;
    localparam state_t RESOLVE = 2'd2;
    localparam state_t COMMIT  = 2'd3;

endpackage

// File: rtl/ball_motion_ctrl_if.sv
// Ball controller bus: scan line and controls in, committed position, directions and event pulses out.
// master = timing/game logic side, slave = ball controller.
interface ball_motion_ctrl_if;

    logic [9:0]  y;
    logic        run;
    logic        serve;
    logic [10:0] xpos;
    logic [9:0]  ypos;
    logic        dir_x;
    logic        dir_y;
    logic        frame_done;
    logic        hit_top;
    logic        hit_bottom;
    logic        miss_left;
    logic        miss_right;

    modport master (
        output y, run, serve,
        input  xpos, ypos, dir_x, dir_y, frame_done,
        input  hit_top, hit_bottom, miss_left, miss_right
    );

    modport slave (
        input  y, run, serve,
        output xpos, ypos, dir_x, dir_y, frame_done,
        output hit_top, hit_bottom, miss_left, miss_right
    );

endinterface

// File: rtl/vblank_tick.sv
// One-cycle tick on the first cycle the scan line reaches the first blanking line.
// Latency: combinational from y; no backpressure.
module vblank_tick #(
    parameter int V_ACTIVE = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] y,
    output logic       tick
);

    localparam logic [9:0] VBLANK_LINE = 10'(V_ACTIVE);

    logic [9:0] y_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) y_prev <= '0;
        else        y_prev <= y;
    end

    assign tick = (y == VBLANK_LINE) && (y_prev != VBLANK_LINE);

endmodule

// File: rtl/ball_motion_ctrl.sv
// Per-frame ball position update with wall bounce, edge miss and re-serve.
// Latency: 3 cycles from vblank tick to committed outputs; no backpressure, a tick outside IDLE is dropped.
module ball_motion_ctrl
    import pong_pkg::*;
#(
    parameter int H_ACTIVE  = pong_pkg::H_ACTIVE,
    parameter int V_ACTIVE  = pong_pkg::V_ACTIVE,
    parameter int BALL_SIZE = 8,
    parameter int WALL_H    = 10,
    parameter int X_START   = 316,
    parameter int Y_START   = 236,
    parameter int STEP      = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    ball_motion_ctrl_if.slave  bus
);

    localparam logic signed [11:0] YMIN  = 12'(WALL_H);
    localparam logic signed [11:0] YMAX  = 12'(V_ACTIVE - WALL_H - BALL_SIZE);
    localparam logic signed [11:0] XMAX  = 12'(H_ACTIVE - BALL_SIZE);
    localparam logic signed [11:0] SSTEP = 12'(STEP);
    localparam logic [10:0]        XS    = 11'(X_START);
    localparam logic [9:0]         YS    = 10'(Y_START);
    localparam logic [9:0]         YMIN_P = 10'(WALL_H);
    localparam logic [9:0]         YMAX_P = 10'(V_ACTIVE - WALL_H - BALL_SIZE);

    logic tick;

    vblank_tick #(.V_ACTIVE(V_ACTIVE)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .y     (bus.y),
        .tick  (tick)
    );

    state_t             state;
    logic [10:0]        xpos;
    logic [9:0]         ypos;
    logic               dir_x;
    logic               dir_y;
    logic               serve_pend;
    logic signed [11:0] nx;
    logic signed [11:0] ny;

    // Resolved candidate, held from RESOLVE until COMMIT
    logic [10:0] rx_q;
    logic [9:0]  ry_q;
    logic        rdx_q, rdy_q;
    logic [3:0]  ev_q;

    logic        frame_done, hit_top, hit_bottom, miss_left, miss_right;

    logic [10:0] rx;
    logic [9:0]  ry;
    logic        rdx, rdy;
    logic        e_ht, e_hb, e_ml, e_mr;
    logic signed [11:0] s;

    assign s = bus.run ? SSTEP : 12'sd0;

    // A miss overrides the clamped y, but a y bounce still flips dir_y
    always_comb begin
        rx   = nx[10:0];
        ry   = ny[9:0];
        rdx  = dir_x;
        rdy  = dir_y;
        e_ht = 1'b0;
        e_hb = 1'b0;
        e_ml = 1'b0;
        e_mr = 1'b0;
        if (dir_y == DIR_DOWN && ny > YMAX) begin
            ry   = YMAX_P;
            rdy  = DIR_UP;
            e_hb = 1'b1;
        end else if (dir_y == DIR_UP && ny < YMIN) begin
            ry   = YMIN_P;
            rdy  = DIR_DOWN;
            e_ht = 1'b1;
        end
        if (dir_x == DIR_LEFT && nx < 12'sd0) begin
            rx   = XS;
            ry   = YS;
            rdx  = DIR_RIGHT;
            e_ml = 1'b1;
        end else if (dir_x == DIR_RIGHT && nx > XMAX) begin
            rx   = XS;
            ry   = YS;
            rdx  = DIR_LEFT;
            e_mr = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            xpos       <= XS;
            ypos       <= YS;
            dir_x      <= DIR_RIGHT;
            dir_y      <= DIR_DOWN;
            serve_pend <= 1'b0;
            nx         <= '0;
            ny         <= '0;
            rx_q       <= '0;
            ry_q       <= '0;
            rdx_q      <= 1'b0;
            rdy_q      <= 1'b0;
            ev_q       <= '0;
            frame_done <= 1'b0;
            hit_top    <= 1'b0;
            hit_bottom <= 1'b0;
            miss_left  <= 1'b0;
            miss_right <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            hit_top    <= 1'b0;
            hit_bottom <= 1'b0;
            miss_left  <= 1'b0;
            miss_right <= 1'b0;
            serve_pend <= serve_pend | bus.serve;
            case (state)
                IDLE: begin
                    if (tick) state <= CALC;
                end
                CALC: begin
                    nx    <= (dir_x == DIR_RIGHT) ? $signed({1'b0, xpos}) + s
                                                  : $signed({1'b0, xpos}) - s;
                    ny    <= (dir_y == DIR_DOWN)  ? $signed({2'b0, ypos}) + s
                                                  : $signed({2'b0, ypos}) - s;
                    state <= RESOLVE;
                end
                RESOLVE: begin
                    rx_q  <= rx;
                    ry_q  <= ry;
                    rdx_q <= rdx;
                    rdy_q <= rdy;
                    ev_q  <= {e_ht, e_hb, e_ml, e_mr};
                    state <= COMMIT;
                end
                default: begin
                    state      <= IDLE;
                    frame_done <= 1'b1;
                    // A serve seen during this COMMIT cycle carries over to the next frame
                    if (serve_pend) begin
                        xpos       <= XS;
                        ypos       <= YS;
                        serve_pend <= bus.serve;
                    end else begin
                        xpos       <= rx_q;
                        ypos       <= ry_q;
                        dir_x      <= rdx_q;
                        dir_y      <= rdy_q;
                        hit_top    <= ev_q[3];
                        hit_bottom <= ev_q[2];
                        miss_left  <= ev_q[1];
                        miss_right <= ev_q[0];
                    end
                end
            endcase
        end
    end

    assign bus.xpos       = xpos;
    assign bus.ypos       = ypos;
    assign bus.dir_x      = dir_x;
    assign bus.dir_y      = dir_y;
    assign bus.frame_done = frame_done;
    assign bus.hit_top    = hit_top;
    assign bus.hit_bottom = hit_bottom;
    assign bus.miss_left  = miss_left;
    assign bus.miss_right = miss_right;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl: reset, stepping, bounce, miss, freeze, serve and mid-update reset.
module tb_ball_motion_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ball_motion_ctrl_if bus ();

    ball_motion_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    function automatic logic [3:0] events();
        return {bus.hit_top, bus.hit_bottom, bus.miss_left, bus.miss_right};
    endfunction

    // Drives one vblank entry and waits (bounded) for the committing cycle.
    task automatic run_frame(output logic ok, output logic [3:0] ev, output int lat);
        ok = 1'b0; ev = '0; lat = 0;
        @(negedge clk) bus.y = 10'd479;
        @(negedge clk) bus.y = 10'd480;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.frame_done) begin
                ok = 1'b1; lat = i; ev = events();
                break;
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0; bus.y = '0; bus.run = 1'b0; bus.serve = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.xpos !== 11'd316 || bus.ypos !== 10'd236) begin
            n_fail++; $display("FAIL reset_pos: got %0d/%0d want 316/236", bus.xpos, bus.ypos);
        end
        n_checks++;
        if (bus.dir_x !== 1'b1 || bus.dir_y !== 1'b1) begin
            n_fail++; $display("FAIL reset_dir: got %b/%b want 1/1", bus.dir_x, bus.dir_y);
        end
        bad = 0;
        repeat (5) begin
            if (bus.frame_done !== 1'b0 || events() !== 4'b0) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL reset_pulses: %0d cycles with pulses, want 0", bad);
        end
    endtask

    task automatic test_single_frame();
        logic ok; logic [3:0] ev; int lat; int bad;
        bus.run = 1'b1;
        run_frame(ok, ev, lat);
        n_checks++;
        if (!ok || lat != 4) begin
            n_fail++; $display("FAIL single_latency: ok=%b lat=%0d want ok=1 lat=4", ok, lat);
        end
        n_checks++;
        if (bus.xpos !== 11'd318 || bus.ypos !== 10'd238 || ev !== 4'b0) begin
            n_fail++; $display("FAIL single_pos: got %0d/%0d ev=%b want 318/238 ev=0000", bus.xpos, bus.ypos, ev);
        end
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.frame_done !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0 || bus.xpos !== 11'd318 || bus.ypos !== 10'd238) begin
            n_fail++; $display("FAIL single_hold: extra pulses=%0d pos=%0d/%0d want 0, 318/238", bad, bus.xpos, bus.ypos);
        end
    endtask

    task automatic test_bottom_bounce();
        logic ok; logic [3:0] ev; int lat; int tout;
        tout = 0;
        for (int f = 2; f <= 113; f++) begin
            run_frame(ok, ev, lat);
            if (!ok) tout++;
        end
        n_checks++;
        if (tout != 0 || bus.ypos !== 10'd462 || bus.dir_y !== 1'b1 || ev !== 4'b0) begin
            n_fail++; $display("FAIL bottom_f113: timeouts=%0d y=%0d dir_y=%b ev=%b want 0,462,1,0000", tout, bus.ypos, bus.dir_y, ev);
        end
        run_frame(ok, ev, lat);
        n_checks++;
        if (!ok || bus.ypos !== 10'd462 || bus.dir_y !== 1'b0 || ev !== 4'b0100) begin
            n_fail++; $display("FAIL bottom_f114: ok=%b y=%0d dir_y=%b ev=%b want 1,462,0,0100", ok, bus.ypos, bus.dir_y, ev);
        end
        n_checks++;
        if (bus.xpos !== 11'd544) begin
            n_fail++; $display("FAIL bottom_x: got %0d want 544", bus.xpos);
        end
    endtask

    task automatic test_right_miss();
        logic ok; logic [3:0] ev; int lat; int tout;
        tout = 0;
        for (int f = 115; f <= 158; f++) begin
            run_frame(ok, ev, lat);
            if (!ok) tout++;
        end
        n_checks++;
        if (tout != 0 || bus.xpos !== 11'd632 || bus.ypos !== 10'd374 || ev !== 4'b0) begin
            n_fail++; $display("FAIL right_f158: timeouts=%0d pos=%0d/%0d ev=%b want 0,632/374,0000", tout, bus.xpos, bus.ypos, ev);
        end
        run_frame(ok, ev, lat);
        n_checks++;
        if (!ok || ev !== 4'b0001 || bus.xpos !== 11'd316 || bus.ypos !== 10'd236) begin
            n_fail++; $display("FAIL right_f159: ok=%b ev=%b pos=%0d/%0d want 1,0001,316/236", ok, ev, bus.xpos, bus.ypos);
        end
        n_checks++;
        if (bus.dir_x !== 1'b0 || bus.dir_y !== 1'b0) begin
            n_fail++; $display("FAIL right_dir: got %b/%b want 0/0", bus.dir_x, bus.dir_y);
        end
    endtask

    task automatic test_freeze_serve();
        logic ok; logic [3:0] ev; int lat; int pulses; int evs;
        bus.run = 1'b0; pulses = 0; evs = 0;
        repeat (5) begin
            run_frame(ok, ev, lat);
            if (ok) pulses++;
            if (ev !== 4'b0) evs++;
        end
        n_checks++;
        if (pulses != 5 || evs != 0 || bus.xpos !== 11'd316 || bus.ypos !== 10'd236) begin
            n_fail++; $display("FAIL freeze: pulses=%0d evs=%0d pos=%0d/%0d want 5,0,316/236", pulses, evs, bus.xpos, bus.ypos);
        end
        bus.run = 1'b1;
        run_frame(ok, ev, lat);
        n_checks++;
        if (!ok || bus.xpos !== 11'd314 || bus.ypos !== 10'd234) begin
            n_fail++; $display("FAIL move_left_up: ok=%b pos=%0d/%0d want 1,314/234", ok, bus.xpos, bus.ypos);
        end
        @(negedge clk) bus.y = 10'd479;
        @(negedge clk) bus.y = 10'd480;
        @(negedge clk);
        @(negedge clk) bus.serve = 1'b1;
        @(negedge clk) bus.serve = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.frame_done !== 1'b1 || bus.xpos !== 11'd316 || bus.ypos !== 10'd236 || events() !== 4'b0) begin
            n_fail++; $display("FAIL serve_commit: fd=%b pos=%0d/%0d ev=%b want 1,316/236,0000", bus.frame_done, bus.xpos, bus.ypos, events());
        end
        n_checks++;
        if (bus.dir_x !== 1'b0 || bus.dir_y !== 1'b0) begin
            n_fail++; $display("FAIL serve_dir: got %b/%b want 0/0", bus.dir_x, bus.dir_y);
        end
        run_frame(ok, ev, lat);
        n_checks++;
        if (!ok || bus.xpos !== 11'd314 || bus.ypos !== 10'd234) begin
            n_fail++; $display("FAIL after_serve: ok=%b pos=%0d/%0d want 1,314/234", ok, bus.xpos, bus.ypos);
        end
    endtask

    task automatic test_reset_mid();
        logic ok; logic [3:0] ev; int lat; int bad;
        @(negedge clk) bus.y = 10'd479;
        @(negedge clk) bus.y = 10'd480;
        @(negedge clk);
        rst_n = 1'b0; bus.y = 10'd0;
        @(negedge clk);
        n_checks++;
        if (bus.xpos !== 11'd316 || bus.ypos !== 10'd236 || bus.dir_x !== 1'b1 || bus.dir_y !== 1'b1 || bus.frame_done !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: pos=%0d/%0d dir=%b%b fd=%b want 316/236 11 0", bus.xpos, bus.ypos, bus.dir_x, bus.dir_y, bus.frame_done);
        end
        rst_n = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.frame_done !== 1'b0 || events() !== 4'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL mid_reset_quiet: %0d pulse cycles want 0", bad);
        end
        run_frame(ok, ev, lat);
        n_checks++;
        if (!ok || lat != 4 || bus.xpos !== 11'd318 || bus.ypos !== 10'd238 || ev !== 4'b0) begin
            n_fail++; $display("FAIL mid_reset_next: ok=%b lat=%0d pos=%0d/%0d ev=%b want 1,4,318/238,0000", ok, lat, bus.xpos, bus.ypos, ev);
        end
    endtask

    initial begin
        bus.y = '0; bus.run = 1'b0; bus.serve = 1'b0;
        test_reset();
        test_single_frame();
        test_bottom_bounce();
        test_right_miss();
        test_freeze_serve();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
